// File: rtl/time_keeper.sv
// time_keeper: live time-of-day counter, edit shadow, alarm store/ring and
// registered display mux driven by the front-panel UI controls.
// Ports:
//   sys_clk, rst_n           clock, async active-low reset
//   tick_1hz                 1 Hz single-cycle pulse
//   display_mode_in[2:0]     UI mode (display/set h/set m/alarm h/alarm m)
//   inc_*_en, load_time_en   single-cycle edit/commit pulses
//   alarm_enable, alarm_stop alarm arm level / silence pulse
//   time_*                   live time (binary h/m/s)
//   disp_*                   registered display values
//   alarm_ring               alarm active
module time_keeper #(
   parameter int unsigned RING_SECONDS = 60
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic [2:0] display_mode_in,
   input  logic       inc_current_hours_en,
   input  logic       inc_current_minutes_en,
   input  logic       inc_alarm_hours_en,
   input  logic       inc_alarm_minutes_en,
   input  logic       load_time_en,
   input  logic       alarm_enable,
   input  logic       alarm_stop,
   output logic [4:0] time_hours,
   output logic [5:0] time_minutes,
   output logic [5:0] time_seconds,
   output logic [4:0] disp_hours,
   output logic [5:0] disp_minutes,
   output logic [5:0] disp_seconds,
   output logic       alarm_ring
);

   localparam logic [7:0] RING_LD = 8'(RING_SECONDS);

   logic [4:0] hr_q;
   logic [5:0] min_q, sec_q;
   logic [4:0] sh_h_q, al_h_q;
   logic [5:0] sh_m_q, al_m_q;
   logic [2:0] prev_mode_q;
   logic       ring_q;
   logic [7:0] ring_cnt_q;
   logic [4:0] dh_q;
   logic [5:0] dm_q, ds_q;

   logic [4:0] hr_d;
   logic [5:0] min_d, sec_d;
   logic       tick_eff;
   logic       trig;
   logic       load_sh;
   logic [4:0] dh_d;
   logic [5:0] dm_d, ds_d;

   // A commit swallows a coincident tick.
   assign tick_eff = tick_1hz & ~load_time_en;
   assign load_sh  = (display_mode_in == 3'b001) &&
                     (prev_mode_q == 3'b000);

   always_comb begin
      sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
      min_d = min_q;
      hr_d  = hr_q;
      if (sec_q == 6'd59) begin
         min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
         if (min_q == 6'd59)
            hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
      end
   end

   // Only a tick landing on hh:mm:00 can trigger; commits never do.
   assign trig = tick_eff & alarm_enable &
                 (sec_q == 6'd59) &
                 (min_d == al_m_q) & (hr_d == al_h_q);

   always_comb begin
      dh_d = hr_q;
      dm_d = min_q;
      ds_d = sec_q;
      case (display_mode_in)
         3'b001, 3'b010: begin
            dh_d = sh_h_q;
            dm_d = sh_m_q;
            ds_d = 6'd0;
         end
         3'b011, 3'b100: begin
            dh_d = al_h_q;
            dm_d = al_m_q;
            ds_d = 6'd0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         hr_q  <= '0;
         min_q <= '0;
         sec_q <= '0;
      end else if (load_time_en) begin
         hr_q  <= sh_h_q;
         min_q <= sh_m_q;
         sec_q <= '0;
      end else if (tick_eff) begin
         hr_q  <= hr_d;
         min_q <= min_d;
         sec_q <= sec_d;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_h_q <= '0;
         sh_m_q <= '0;
      end else if (load_sh) begin
         sh_h_q <= hr_q;
         sh_m_q <= min_q;
      end else begin
         if (inc_current_hours_en)
            sh_h_q <= (sh_h_q == 5'd23) ? 5'd0 : sh_h_q + 5'd1;
         if (inc_current_minutes_en)
            sh_m_q <= (sh_m_q == 6'd59) ? 6'd0 : sh_m_q + 6'd1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         al_h_q <= '0;
         al_m_q <= '0;
      end else begin
         if (inc_alarm_hours_en)
            al_h_q <= (al_h_q == 5'd23) ? 5'd0 : al_h_q + 5'd1;
         if (inc_alarm_minutes_en)
            al_m_q <= (al_m_q == 6'd59) ? 6'd0 : al_m_q + 6'd1;
      end
   end

   // Stop/disable beat a trigger; a trigger while ringing reloads.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         ring_q     <= 1'b0;
         ring_cnt_q <= '0;
      end else if (alarm_stop || !alarm_enable) begin
         ring_q     <= 1'b0;
         ring_cnt_q <= '0;
      end else if (trig) begin
         ring_q     <= 1'b1;
         ring_cnt_q <= RING_LD;
      end else if (tick_eff && ring_q) begin
         if (ring_cnt_q <= 8'd1) begin
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
         end else begin
            ring_cnt_q <= ring_cnt_q - 8'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_mode_q <= 3'b000;
         dh_q        <= '0;
         dm_q        <= '0;
         ds_q        <= '0;
      end else begin
         prev_mode_q <= display_mode_in;
         dh_q        <= dh_d;
         dm_q        <= dm_d;
         ds_q        <= ds_d;
      end
   end

   assign time_hours   = hr_q;
   assign time_minutes = min_q;
   assign time_seconds = sec_q;
   assign disp_hours   = dh_q;
   assign disp_minutes = dm_q;
   assign disp_seconds = ds_q;
   assign alarm_ring   = ring_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed stimulus with a queued scoreboard; values are
// packed as hh*10000 + mm*100 + ss for compact expectations.
module tb_time_keeper;

   logic       sys_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1hz = 1'b0;
   logic [2:0] display_mode_in = 3'b000;
   logic       inc_current_hours_en = 1'b0;
   logic       inc_current_minutes_en = 1'b0;
   logic       inc_alarm_hours_en = 1'b0;
   logic       inc_alarm_minutes_en = 1'b0;
   logic       load_time_en = 1'b0;
   logic       alarm_enable = 1'b0;
   logic       alarm_stop = 1'b0;
   logic [4:0] time_hours, disp_hours;
   logic [5:0] time_minutes, time_seconds;
   logic [5:0] disp_minutes, disp_seconds;
   logic       alarm_ring;

   time_keeper #(.RING_SECONDS(3)) dut (
      .sys_clk(sys_clk),
      .rst_n(rst_n),
      .tick_1hz(tick_1hz),
      .display_mode_in(display_mode_in),
      .inc_current_hours_en(inc_current_hours_en),
      .inc_current_minutes_en(inc_current_minutes_en),
      .inc_alarm_hours_en(inc_alarm_hours_en),
      .inc_alarm_minutes_en(inc_alarm_minutes_en),
      .load_time_en(load_time_en),
      .alarm_enable(alarm_enable),
      .alarm_stop(alarm_stop),
      .time_hours(time_hours),
      .time_minutes(time_minutes),
      .time_seconds(time_seconds),
      .disp_hours(disp_hours),
      .disp_minutes(disp_minutes),
      .disp_seconds(disp_seconds),
      .alarm_ring(alarm_ring)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      int    due;
      string nm;
      int    sel;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   mh = 0, mm = 0, ms = 0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   function automatic int cur(int sel);
      case (sel)
         0: return int'(time_hours) * 10000 +
                   int'(time_minutes) * 100 + int'(time_seconds);
         1: return int'(disp_hours) * 10000 +
                   int'(disp_minutes) * 100 + int'(disp_seconds);
         default: return int'(alarm_ring);
      endcase
   endfunction

   // Monitor: wakes after each clock edge (and on reset assertion).
   initial begin
      forever begin
         @(posedge sys_clk or negedge rst_n);
         #1;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
               total++;
               if (cur(sb[i].sel) != sb[i].val) begin
                  bad++;
                  $display("FAIL %s: got %0d want %0d",
                           sb[i].nm, cur(sb[i].sel), sb[i].val);
               end
               sb.delete(i);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(string nm, int sel, int val, int d = 1);
      exp_t e;
      e.due = cyc + d;
      e.nm  = nm;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic idle(int n = 1);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic tick1();
      tick_1hz = 1'b1;
      @(negedge sys_clk);
      tick_1hz = 1'b0;
      ms++;
      if (ms == 60) begin
         ms = 0;
         mm++;
         if (mm == 60) begin
            mm = 0;
            mh = (mh + 1) % 24;
         end
      end
   endtask

   task automatic ticks(int n);
      repeat (n) tick1();
   endtask

   task automatic set_time(int h, int m);
      display_mode_in = 3'b001;
      @(negedge sys_clk);
      inc_current_hours_en = 1'b1;
      repeat ((h - mh + 24) % 24) @(negedge sys_clk);
      inc_current_hours_en = 1'b0;
      inc_current_minutes_en = 1'b1;
      repeat ((m - mm + 60) % 60) @(negedge sys_clk);
      inc_current_minutes_en = 1'b0;
      load_time_en = 1'b1;
      @(negedge sys_clk);
      load_time_en = 1'b0;
      display_mode_in = 3'b000;
      @(negedge sys_clk);
      mh = h;
      mm = m;
      ms = 0;
   endtask

   task automatic arm();
      set_time(6, 29);
      ticks(59);
      tick1();
   endtask

   initial begin
      idle(3);
      chk("rst_time_held", 0, 0);
      chk("rst_ring_held", 2, 0);
      idle(1);
      rst_n = 1'b1;
      chk("rst_time", 0, 0);
      chk("rst_disp", 1, 0);
      chk("rst_ring", 2, 0);
      idle(2);

      set_time(23, 59);
      ticks(58);
      chk("wrap_pre", 0, 235958);
      idle();
      tick1();
      chk("wrap_59", 0, 235959);
      idle();
      tick1();
      chk("wrap_time", 0, 0);
      chk("wrap_disp", 1, 0);
      idle();

      set_time(10, 19);
      ticks(90);
      chk("edit_live", 0, 102030);
      idle();
      display_mode_in = 3'b001;
      inc_current_hours_en = 1'b1;
      @(negedge sys_clk);
      repeat (3) @(negedge sys_clk);
      inc_current_hours_en = 1'b0;
      chk("edit_sh_hours", 1, 132000);
      idle();
      display_mode_in = 3'b010;
      inc_current_minutes_en = 1'b1;
      repeat (45) @(negedge sys_clk);
      inc_current_minutes_en = 1'b0;
      chk("edit_sh_min_wrap", 1, 130500);
      idle();
      load_time_en = 1'b1;
      @(negedge sys_clk);
      load_time_en = 1'b0;
      chk("commit_time", 0, 130500);
      display_mode_in = 3'b000;
      idle();
      mh = 13;
      mm = 5;
      ms = 0;
      chk("commit_disp", 1, 130500);
      idle();

      display_mode_in = 3'b001;
      @(negedge sys_clk);
      inc_current_hours_en = 1'b1;
      repeat (9) @(negedge sys_clk);
      inc_current_hours_en = 1'b0;
      chk("sh_h_22", 1, 220500);
      idle();
      inc_current_hours_en = 1'b1;
      @(negedge sys_clk);
      inc_current_hours_en = 1'b0;
      chk("sh_h_23", 1, 230500);
      idle();
      inc_current_hours_en = 1'b1;
      @(negedge sys_clk);
      inc_current_hours_en = 1'b0;
      chk("sh_h_0", 1, 500);
      idle();
      display_mode_in = 3'b000;
      idle();

      ticks(5);
      chk("cvt_pre", 0, 130505);
      idle();
      display_mode_in = 3'b001;
      @(negedge sys_clk);
      load_time_en = 1'b1;
      tick_1hz = 1'b1;
      @(negedge sys_clk);
      load_time_en = 1'b0;
      tick_1hz = 1'b0;
      chk("commit_vs_tick", 0, 130500);
      display_mode_in = 3'b000;
      idle();
      ms = 0;

      display_mode_in = 3'b011;
      inc_alarm_hours_en = 1'b1;
      repeat (6) @(negedge sys_clk);
      inc_alarm_hours_en = 1'b0;
      display_mode_in = 3'b100;
      inc_alarm_minutes_en = 1'b1;
      repeat (30) @(negedge sys_clk);
      inc_alarm_minutes_en = 1'b0;
      chk("alarm_disp", 1, 63000);
      idle();
      display_mode_in = 3'b000;
      alarm_enable = 1'b1;
      idle();

      set_time(6, 29);
      ticks(59);
      chk("alm_pre_time", 0, 62959);
      chk("alm_pre_ring", 2, 0);
      idle();
      tick1();
      chk("alm_trig_ring", 2, 1);
      chk("alm_trig_time", 0, 63000);
      idle();
      ticks(2);
      chk("alm_ring_2", 2, 1);
      idle();
      tick1();
      chk("alm_auto_stop", 2, 0);
      idle();

      arm();
      chk("stop_armed", 2, 1);
      idle();
      alarm_stop = 1'b1;
      @(negedge sys_clk);
      alarm_stop = 1'b0;
      chk("stop_clear", 2, 0);
      idle();

      set_time(6, 29);
      ticks(59);
      alarm_stop = 1'b1;
      tick1();
      alarm_stop = 1'b0;
      chk("stop_suppress", 2, 0);
      chk("stop_sup_time", 0, 63000);
      idle();

      arm();
      chk("dis_armed", 2, 1);
      idle();
      alarm_enable = 1'b0;
      @(negedge sys_clk);
      chk("dis_clear", 2, 0);
      idle();
      alarm_enable = 1'b1;

      set_time(6, 30);
      chk("commit_noring", 2, 0);
      chk("commit_0630", 0, 63000);
      idle();
      tick1();
      chk("post_commit_time", 0, 63001);
      chk("post_commit_ring", 2, 0);
      idle();

      arm();
      chk("rst_mid_armed", 2, 1);
      idle();
      display_mode_in = 3'b001;
      @(negedge sys_clk);
      inc_current_hours_en = 1'b1;
      repeat (2) @(negedge sys_clk);
      inc_current_hours_en = 1'b0;
      chk("async_rst_time", 0, 0, 0);
      chk("async_rst_disp", 1, 0, 0);
      chk("async_rst_ring", 2, 0, 0);
      #3;
      rst_n = 1'b0;
      display_mode_in = 3'b000;
      idle(2);
      rst_n = 1'b1;
      mh = 0;
      mm = 0;
      ms = 0;
      idle();
      ticks(3);
      chk("post_rst_time", 0, 3);
      chk("post_rst_disp", 1, 3);
      chk("post_rst_ring", 2, 0);
      idle(3);

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL sb_drain: got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
